mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 16, address width of all ports.
REQ-002 Parameter DWIDTH, default 16, data width of all ports.
REQ-003 Parameter MAXWAIT, default 3, consecutive fetch denials before fetch is forced to win.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  1  fetch port read request, held until acked.
REQ-007 i_addr  input  AWIDTH  fetch read address.
REQ-008 i_ack  output  1  fetch request accepted this cycle.
REQ-009 i_rvalid  output  1  fetch read data valid pulse.
REQ-010 i_rdata  output  DWIDTH  fetch read data, held until next fetch response.
REQ-011 d_req  input  1  data port request, held until acked.
REQ-012 d_we  input  1  data request is a write (1) or read (0).
REQ-013 d_addr  input  AWIDTH  data port address.
REQ-014 d_wdata  input  DWIDTH  data port write data.
REQ-015 d_ack  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data read data valid pulse; never set for writes.
REQ-017 d_rdata  output  DWIDTH  data read data, held until next data read response.
REQ-018 mem_re, mem_raddr  output  1, AWIDTH  read strobe/address to the synchronous memory.
REQ-019 mem_rdata  input  DWIDTH  memory read data, valid the cycle after mem_re was sampled.
REQ-020 mem_we, mem_waddr, mem_wdata  output  1, AWIDTH, DWIDTH  write strobe/address/data to memory.

Function
REQ-021 Exactly one request SHALL be granted per cycle; mem_re and mem_we SHALL never be high together.
REQ-022 Grant, ack and mem_* command outputs SHALL be combinational from requests and registered arbitration state; acked request issues to memory in the same cycle.
REQ-023 Priority: data port wins when both request, unless starve counter == MAXWAIT, then fetch wins.
REQ-024 Starve counter (width ceil(log2(MAXWAIT+1))): increments, saturating at MAXWAIT, each cycle i_req is high and not granted; clears when fetch granted or i_req low.
REQ-025 Granted read: mem_re=1, mem_raddr=port address; a registered owner tag (FETCH/DATA) and pending bit SHALL record it.
REQ-026 Granted write: mem_we=1, mem_waddr=d_addr, mem_wdata=d_wdata; pending bit not set.
REQ-027 Cycle N+1 after a read issue: capture mem_rdata into owner's rdata register at end of N+1; owner's rvalid SHALL be high in cycle N+2 for exactly one cycle (issue-to-rvalid latency 2).
REQ-028 Reads back-to-back every cycle SHALL be supported; pipeline holds issue tag (stage 1) and capture-valid (stage 2) independently, giving throughput 1 read/cycle.
REQ-029 Write then read to same address in consecutive cycles SHALL return the new data (memory order preserved; no reordering).
REQ-030 When memory is idle (no grant), mem_raddr/mem_waddr/mem_wdata SHALL be 0.
REQ-031 Requests dropped before ack SHALL be ignored; no ack for a cycle with req low.
REQ-032 i_rdata/d_rdata SHALL only change on their own port's capture.

Reset
REQ-033 While rst is low: i_ack, d_ack, i_rvalid, d_rvalid, mem_re, mem_we = 0; i_rdata, d_rdata = 0; starve counter, pending bits, owner tags cleared.
REQ-034 Reset asserted mid-read SHALL discard the in-flight response; no rvalid after rst deasserts for reads issued before it.
REQ-035 First grant possible in the first rising edge cycle after rst goes high.

Verification
REQ-036 Fetch only: i_req, i_addr=0x0010, mem holds 0xBEEF -> i_ack cycle N, mem_re/mem_raddr=0x0010 cycle N, i_rvalid with i_rdata=0xBEEF cycle N+2.
REQ-037 Contention: i_req and d_req (read 0x0020) held continuously, MAXWAIT=3 -> d_ack cycles 0..2, i_ack cycle 3, pattern repeats; never both acks in one cycle.
REQ-038 Write/read: d_we write 0x1234 to 0x0005 cycle N, d read 0x0005 cycle N+1 -> d_rvalid cycle N+3 with d_rdata=0x1234; no d_rvalid at N+2.
REQ-039 Streaming: fetch reads 0x0,0x1,0x2,0x3 back-to-back -> i_rvalid four consecutive cycles, data in address order.
REQ-040 Reset mid-operation: issue fetch read, pull rst low cycle N+1 for one cycle -> all outputs 0 immediately, no i_rvalid afterwards, i_rdata stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and synchronous-memory signals around mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
);
  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic              i_ack;
  logic              i_rvalid;
  logic [DWIDTH-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [DWIDTH-1:0] d_rdata;

  logic              mem_re;
  logic [AWIDTH-1:0] mem_raddr;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one synchronous memory; grant is same-cycle, read data returns 2 cycles after issue.
// Data port has priority; fetch is forced through after MAXWAIT consecutive denials. No backpressure on responses.
module mem_arbiter #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 16,
  parameter int MAXWAIT = 3
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  typedef enum logic { OWN_FETCH = 1'b0, OWN_DATA = 1'b1 } owner_t;

  logic [SW-1:0]     starve;
  logic              s1_vld;
  owner_t            s1_owner;
  logic              i_rvalid_q, d_rvalid_q;
  logic [DWIDTH-1:0] i_rdata_q, d_rdata_q;

  logic starve_max, grant_i, grant_d, rd_issue, wr_issue;

  // Grants are gated by reset so every command output is quiet while rst is low.
  always_comb begin
    starve_max = (starve == SW'(MAXWAIT));
    grant_i    = rst & bus.i_req & (~bus.d_req | starve_max);
    grant_d    = rst & bus.d_req & ~grant_i;
    rd_issue   = grant_i | (grant_d & ~bus.d_we);
    wr_issue   = grant_d & bus.d_we;
  end

  assign bus.i_ack     = grant_i;
  assign bus.d_ack     = grant_d;
  assign bus.mem_re    = rd_issue;
  assign bus.mem_raddr = grant_i ? bus.i_addr :
                         (rd_issue ? bus.d_addr : '0);
  assign bus.mem_we    = wr_issue;
  assign bus.mem_waddr = wr_issue ? bus.d_addr  : '0;
  assign bus.mem_wdata = wr_issue ? bus.d_wdata : '0;

  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve     <= '0;
      s1_vld     <= 1'b0;
      s1_owner   <= OWN_FETCH;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_i || !bus.i_req)
        starve <= '0;
      else if (!starve_max)
        starve <= starve + SW'(1);

      // Stage 1 tags the read in flight; stage 2 captures memory data for its owner.
      s1_vld   <= rd_issue;
      s1_owner <= grant_i ? OWN_FETCH : OWN_DATA;

      i_rvalid_q <= s1_vld && (s1_owner == OWN_FETCH);
      d_rvalid_q <= s1_vld && (s1_owner == OWN_DATA);
      if (s1_vld && (s1_owner == OWN_FETCH))
        i_rdata_q <= bus.mem_rdata;
      if (s1_vld && (s1_owner == OWN_DATA))
        d_rdata_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  logic [15:0] mem [0:255];

  mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus ();

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .MAXWAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr[7:0]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr[7:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'h5555;
    for (int a = 0; a < 4; a++) mem[a] = 16'hA000 + 16'(a);
    bus.mem_rdata = '0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    // reset state, with a request held to show it is not granted
    tick(); tick();
    sample();
    check_val("rst_d_ack",   32'(bus.d_ack),    0);
    check_val("rst_mem_re",  32'(bus.mem_re),   0);
    check_val("rst_mem_we",  32'(bus.mem_we),   0);
    check_val("rst_i_rvld",  32'(bus.i_rvalid), 0);
    check_val("rst_d_rvld",  32'(bus.d_rvalid), 0);
    check_val("rst_i_rdata", 32'(bus.i_rdata),  0);
    check_val("rst_d_rdata", 32'(bus.d_rdata),  0);
    tick();
    rst = 1; bus.d_req = 0;

    // fetch-only read of 0x0010
    bus.i_req = 1; bus.i_addr = 16'h0010;
    sample();
    check_val("f_i_ack",     32'(bus.i_ack),     1);
    check_val("f_d_ack",     32'(bus.d_ack),     0);
    check_val("f_mem_re",    32'(bus.mem_re),    1);
    check_val("f_mem_raddr", 32'(bus.mem_raddr), 32'h10);
    check_val("f_mem_we",    32'(bus.mem_we),    0);
    tick(); bus.i_req = 0;
    sample();
    check_val("f_n1_ack",    32'(bus.i_ack),     0);
    check_val("f_n1_rvld",   32'(bus.i_rvalid),  0);
    check_val("idle_raddr",  32'(bus.mem_raddr), 0);
    check_val("idle_waddr",  32'(bus.mem_waddr), 0);
    check_val("idle_wdata",  32'(bus.mem_wdata), 0);
    tick();
    sample();
    check_val("f_n2_rvld",   32'(bus.i_rvalid),  1);
    check_val("f_n2_rdata",  32'(bus.i_rdata),   32'hBEEF);
    tick();
    sample();
    check_val("f_n3_rvld",   32'(bus.i_rvalid),  0);
    check_val("f_n3_rdata",  32'(bus.i_rdata),   32'hBEEF);
    tick();

    // contention: data wins 3 times, fetch forced on the 4th
    bus.i_req = 1; bus.i_addr = 16'h0010;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020;
    for (int k = 0; k < 8; k++) begin
      sample();
      check_val($sformatf("c_d_ack%0d", k), 32'(bus.d_ack), ((k % 4) != 3) ? 1 : 0);
      check_val($sformatf("c_i_ack%0d", k), 32'(bus.i_ack), ((k % 4) == 3) ? 1 : 0);
      tick();
    end
    bus.i_req = 0; bus.d_req = 0;
    tick(); tick(); tick();

    // write then read same address on consecutive cycles
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0005; bus.d_wdata = 16'h1234;
    sample();
    check_val("w_d_ack",     32'(bus.d_ack),     1);
    check_val("w_mem_we",    32'(bus.mem_we),    1);
    check_val("w_mem_re",    32'(bus.mem_re),    0);
    check_val("w_waddr",     32'(bus.mem_waddr), 32'h5);
    check_val("w_wdata",     32'(bus.mem_wdata), 32'h1234);
    tick(); bus.d_we = 0;
    sample();
    check_val("r_mem_re",    32'(bus.mem_re),    1);
    check_val("r_raddr",     32'(bus.mem_raddr), 32'h5);
    check_val("r_mem_we",    32'(bus.mem_we),    0);
    tick(); bus.d_req = 0;
    sample();
    check_val("wr_n2_rvld",  32'(bus.d_rvalid),  0);
    tick();
    sample();
    check_val("wr_n3_rvld",  32'(bus.d_rvalid),  1);
    check_val("wr_n3_rdata", 32'(bus.d_rdata),   32'h1234);
    check_val("wr_i_rdata",  32'(bus.i_rdata),   32'hBEEF);
    tick(); tick();

    // back-to-back fetch reads 0..3
    for (int k = 0; k < 7; k++) begin
      bus.i_req  = (k < 4);
      bus.i_addr = 16'(k);
      sample();
      check_val($sformatf("s_ack%0d", k),  32'(bus.i_ack),    (k < 4) ? 1 : 0);
      check_val($sformatf("s_rvld%0d", k), 32'(bus.i_rvalid), (k >= 2 && k < 6) ? 1 : 0);
      check_val($sformatf("s_drv%0d", k),  32'(bus.d_rvalid), 0);
      if (k >= 2 && k < 6)
        check_val($sformatf("s_data%0d", k), 32'(bus.i_rdata), 32'hA000 + 32'(k - 2));
      tick();
    end
    bus.i_req = 0;
    tick();

    // reset pulled one cycle after a fetch issue
    bus.i_req = 1; bus.i_addr = 16'h0002;
    sample();
    check_val("rm_i_ack",    32'(bus.i_ack),     1);
    tick();
    bus.i_req = 0; bus.d_req = 1; bus.d_we = 0; rst = 0;
    sample();
    check_val("rm_d_ack",    32'(bus.d_ack),     0);
    check_val("rm_mem_re",   32'(bus.mem_re),    0);
    check_val("rm_i_rvld",   32'(bus.i_rvalid),  0);
    check_val("rm_i_rdata",  32'(bus.i_rdata),   0);
    tick();
    rst = 1; bus.d_req = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_val($sformatf("rm_post_rvld%0d", k),  32'(bus.i_rvalid), 0);
      check_val($sformatf("rm_post_rdata%0d", k), 32'(bus.i_rdata),  0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
